// File: rtl/trap_controller.sv
// Trap controller: sequences the machine-mode CSR file on synchronous traps and mret.
// It arbitrates the exception sources, latches the trap PC, instruction and cause, and pulses
// the CSR block. It then flushes the pipeline and redirects fetch to mtvec (trap) or mepc (mret).
// Optional feature: define TRAP_IRQ_EN to add the external interrupt inputs
// (irq_ext_i, mstatus_mie_i, mie_meie_i).
module trap_controller #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [7:0]  IRQ_CODE     = 8'h8B
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      exc_valid_i,
    input  logic [NUM_SRC*8-1:0]    exc_code_i,
    input  logic [DATA_WIDTH-1:0]   exc_pc_i,
    input  logic [DATA_WIDTH-1:0]   exc_instr_i,
    input  logic                    mret_i,
    input  logic [DATA_WIDTH-1:0]   csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0]   csr_mepc_i,
`ifdef TRAP_IRQ_EN
    input  logic                    irq_ext_i,
    input  logic                    mstatus_mie_i,
    input  logic                    mie_meie_i,
`endif
    output logic                    csr_exception_o,
    output logic [7:0]              csr_exception_code_o,
    output logic [DATA_WIDTH-1:0]   csr_pc_o,
    output logic [DATA_WIDTH-1:0]   csr_instr_o,
    output logic                    flush_o,
    output logic                    stall_o,
    output logic                    redirect_valid_o,
    output logic [DATA_WIDTH-1:0]   redirect_pc_o,
    output logic [15:0]             trap_count_o
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSignal   = 2'd1;
    localparam logic [1:0] StFlush    = 2'd2;
    localparam logic [1:0] StRedirect = 2'd3;

    // Counter is loaded with the last index so FLUSH lasts exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  is_mret_q, is_mret_d;
    logic [7:0]            code_q, code_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [15:0]           count_q, count_d;

    logic                  sel_hit;
    logic [7:0]            sel_code;
    logic                  irq_take;

    // Fixed-priority select: the lowest set index wins, so scan downwards and let it overwrite.
    always_comb begin
        sel_hit  = 1'b0;
        sel_code = 8'h00;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (exc_valid_i[i]) begin
                sel_hit  = 1'b1;
                sel_code = exc_code_i[8*i +: 8];
            end
        end
    end

`ifdef TRAP_IRQ_EN
    assign irq_take = irq_ext_i & mstatus_mie_i & mie_meie_i;
`else
    assign irq_take = 1'b0;
`endif

    // Next-state logic for the trap sequence, latched trap info and the trap counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mret_d = is_mret_q;
        code_d    = code_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        count_d   = count_q;
        case (state_q)
            StIdle: begin
                // Priority: exception > mret > interrupt.
                if (sel_hit) begin
                    code_d    = sel_code;
                    pc_d      = exc_pc_i;
                    instr_d   = exc_instr_i;
                    is_mret_d = 1'b0;
                    state_d   = StSignal;
                end else if (mret_i) begin
                    is_mret_d = 1'b1;
                    cnt_d     = FlushLast;
                    state_d   = StFlush;
                end else if (irq_take) begin
                    // exc_pc_i is the next PC to resume at; there is no faulting instruction.
                    code_d    = IRQ_CODE;
                    pc_d      = exc_pc_i;
                    instr_d   = '0;
                    is_mret_d = 1'b0;
                    state_d   = StSignal;
                end
            end
            StSignal: begin
                count_d = count_q + 16'd1;
                cnt_d   = FlushLast;
                state_d = StFlush;
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRedirect;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRedirect: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset; reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            is_mret_q <= 1'b0;
            code_q    <= 8'h00;
            pc_q      <= '0;
            instr_q   <= '0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_mret_q <= is_mret_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            count_q   <= count_d;
        end
    end

    // Outputs decoded from state; the redirect target is sampled live so late CSR writes show.
    always_comb begin
        csr_exception_o      = (state_q == StSignal);
        flush_o              = (state_q == StFlush);
        redirect_valid_o     = (state_q == StRedirect);
        stall_o              = (state_q != StIdle);
        redirect_pc_o        = '0;
        if (state_q == StRedirect) begin
            redirect_pc_o = is_mret_q ? csr_mepc_i : csr_mtvec_i;
        end
        csr_exception_code_o = code_q;
        csr_pc_o             = pc_q;
        csr_instr_o          = instr_q;
        trap_count_o         = count_q;
    end

endmodule
